// File: rtl/piezo_alert_sched_if.sv
// Alert request / piezo tone configuration bundle.
//   master : drives the three level requests, observes the tone configuration
//   slave  : the scheduler; consumes requests, drives tone_en/period/duty/active_src
interface piezo_alert_sched_if;
   logic        ovr_spd_req;
   logic        batt_low_req;
   logic        en_steer_req;
   logic        tone_en;
   logic [20:0] tone_period;
   logic [19:0] tone_duty;
   logic [1:0]  active_src;

   modport master (
      output ovr_spd_req,
      output batt_low_req,
      output en_steer_req,
      input  tone_en,
      input  tone_period,
      input  tone_duty,
      input  active_src
   );

   modport slave (
      input  ovr_spd_req,
      input  batt_low_req,
      input  en_steer_req,
      output tone_en,
      output tone_period,
      output tone_duty,
      output active_src
   );
endinterface

// File: rtl/piezo_alert_sched.sv
// Audible alert sequencer for the segway piezo.
// Arbitrates overspeed / low-battery / steer-enable requests by fixed priority
// (OVR > BATT > STEER) and plays a per-alert beep-on / beep-off pattern,
// driving period, duty and enable into the downstream piezo PWM.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave modport) : ovr_spd_req, batt_low_req, en_steer_req (level, sync to clk)
//                         tone_en, tone_period[20:0], tone_duty[19:0], active_src[1:0]
//                         active_src: 0=NONE 1=STEER 2=BATT 3=OVR
module piezo_alert_sched #(
   parameter int unsigned TICK_DIV     = 50000,
   parameter logic [20:0] OVR_PERIOD   = 21'h00E400,
   parameter logic [20:0] BATT_PERIOD  = 21'h03F800,
   parameter logic [20:0] STEER_PERIOD = 21'h01E838,
   parameter int unsigned OVR_ON       = 100,
   parameter int unsigned OVR_OFF      = 100,
   parameter int unsigned BATT_ON      = 500,
   parameter int unsigned BATT_OFF     = 1500,
   parameter int unsigned STEER_ON     = 200,
   parameter int unsigned STEER_OFF    = 1400
) (
   input logic               clk,
   input logic               rst_n,
   piezo_alert_sched_if.slave bus
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned CW = 12;

   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_STEER = 2'd1;
   localparam logic [1:0] SRC_BATT  = 2'd2;
   localparam logic [1:0] SRC_OVR   = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} state_t;
   typedef enum logic [1:0] {ACT_COUNT, ACT_ON, ACT_OFF, ACT_IDLE} act_t;

   state_t          state_q;
   logic [PW-1:0]   presc_q;
   logic [CW-1:0]   cnt_q;
   logic            tone_en_q;
   logic [20:0]     tone_period_q;
   logic [19:0]     tone_duty_q;
   logic [1:0]      src_q;

   logic [1:0]      arb_src;
   logic            cur_req;
   logic [CW-1:0]   on_last;
   logic [CW-1:0]   off_last;
   logic            tick;
   logic            preempt;
   act_t            act;
   logic [1:0]      tgt_src;
   logic [20:0]     tgt_period;

   // Fixed-priority arbitration of the raw request levels.
   always_comb begin
      arb_src = SRC_NONE;
      if (bus.ovr_spd_req)       arb_src = SRC_OVR;
      else if (bus.batt_low_req) arb_src = SRC_BATT;
      else if (bus.en_steer_req) arb_src = SRC_STEER;
   end

   // Per-source request level and last tick index of the on/off phases.
   always_comb begin
      cur_req  = 1'b0;
      on_last  = '0;
      off_last = '0;
      case (src_q)
         SRC_OVR: begin
            cur_req  = bus.ovr_spd_req;
            on_last  = CW'(OVR_ON - 1);
            off_last = CW'(OVR_OFF - 1);
         end
         SRC_BATT: begin
            cur_req  = bus.batt_low_req;
            on_last  = CW'(BATT_ON - 1);
            off_last = CW'(BATT_OFF - 1);
         end
         SRC_STEER: begin
            cur_req  = bus.en_steer_req;
            on_last  = CW'(STEER_ON - 1);
            off_last = CW'(STEER_OFF - 1);
         end
         default: begin
            cur_req  = 1'b0;
            on_last  = '0;
            off_last = '0;
         end
      endcase
   end

   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign preempt = bus.ovr_spd_req && (src_q != SRC_OVR);

   // Next action. Preemption outranks request drop, which outranks phase end.
   always_comb begin
      act     = ACT_COUNT;
      tgt_src = src_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_src != SRC_NONE) begin
               act     = ACT_ON;
               tgt_src = arb_src;
            end else begin
               act = ACT_IDLE;
            end
         end
         ST_ON: begin
            if (preempt) begin
               act     = ACT_ON;
               tgt_src = SRC_OVR;
            end else if (!cur_req) begin
               act = ACT_IDLE;
            end else if (tick && (cnt_q == on_last)) begin
               act = ACT_OFF;
            end
         end
         ST_OFF: begin
            if (preempt) begin
               act     = ACT_ON;
               tgt_src = SRC_OVR;
            end else if (!cur_req) begin
               act = ACT_IDLE;
            end else if (tick && (cnt_q == off_last)) begin
               if (arb_src != SRC_NONE) begin
                  act     = ACT_ON;
                  tgt_src = arb_src;
               end else begin
                  act = ACT_IDLE;
               end
            end
         end
         default: act = ACT_IDLE;
      endcase
   end

   // Tone period for the source about to be entered.
   always_comb begin
      tgt_period = '0;
      case (tgt_src)
         SRC_OVR:   tgt_period = OVR_PERIOD;
         SRC_BATT:  tgt_period = BATT_PERIOD;
         SRC_STEER: tgt_period = STEER_PERIOD;
         default:   tgt_period = '0;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         presc_q       <= '0;
         cnt_q         <= '0;
         tone_en_q     <= 1'b0;
         tone_period_q <= '0;
         tone_duty_q   <= '0;
         src_q         <= SRC_NONE;
      end else begin
         case (act)
            ACT_ON: begin
               state_q       <= ST_ON;
               presc_q       <= '0;
               cnt_q         <= '0;
               tone_en_q     <= 1'b1;
               tone_period_q <= tgt_period;
               tone_duty_q   <= tgt_period[20:1];
               src_q         <= tgt_src;
            end
            ACT_OFF: begin
               state_q     <= ST_OFF;
               presc_q     <= '0;
               cnt_q       <= '0;
               tone_en_q   <= 1'b0;
               tone_duty_q <= '0;
            end
            ACT_IDLE: begin
               state_q       <= ST_IDLE;
               presc_q       <= '0;
               cnt_q         <= '0;
               tone_en_q     <= 1'b0;
               tone_period_q <= '0;
               tone_duty_q   <= '0;
               src_q         <= SRC_NONE;
            end
            default: begin
               if (tick) begin
                  presc_q <= '0;
                  cnt_q   <= cnt_q + CW'(1);
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
         endcase
      end
   end

   assign bus.tone_en     = tone_en_q;
   assign bus.tone_period = tone_period_q;
   assign bus.tone_duty   = tone_duty_q;
   assign bus.active_src  = src_q;

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Bench for piezo_alert_sched: each row of the scoreboard queue holds the
// request levels to drive before an edge and the outputs required after it.
module tb_piezo_alert_sched;

   localparam logic [20:0] P_OVR   = 21'h00E400;
   localparam logic [20:0] P_BATT  = 21'h03F800;
   localparam logic [20:0] P_STEER = 21'h01E838;

   // request vector order: {ovr, batt, steer}
   localparam logic [2:0] R_NONE  = 3'b000;
   localparam logic [2:0] R_S     = 3'b001;
   localparam logic [2:0] R_B     = 3'b010;
   localparam logic [2:0] R_BS    = 3'b011;
   localparam logic [2:0] R_O     = 3'b100;
   localparam logic [2:0] R_OS    = 3'b101;
   localparam logic [2:0] R_OB    = 3'b110;

   typedef struct {
      logic [2:0]  req;
      logic [43:0] exp;   // {tone_en, tone_period, tone_duty, active_src}
   } row_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   row_t sb[$];

   always #5 clk = ~clk;

   piezo_alert_sched_if bus_if ();

   piezo_alert_sched #(
      .TICK_DIV (4),
      .OVR_ON   (2),
      .OVR_OFF  (2),
      .BATT_ON  (3),
      .BATT_OFF (5),
      .STEER_ON (1),
      .STEER_OFF(6)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   function automatic logic [20:0] per_of(input logic [1:0] src);
      case (src)
         2'd3:    return P_OVR;
         2'd2:    return P_BATT;
         2'd1:    return P_STEER;
         default: return 21'd0;
      endcase
   endfunction

   // Queue n rows: drive req, expect beep state en for source src.
   task automatic push(input int n, input logic [2:0] req, input logic en, input logic [1:0] src);
      row_t        r;
      logic [20:0] per;
      logic [19:0] duty;
      per  = per_of(src);
      duty = en ? per[20:1] : 20'd0;
      r.req = req;
      r.exp = {en, per, duty, src};
      for (int i = 0; i < n; i++) sb.push_back(r);
   endtask

   function automatic logic [43:0] observed();
      return {bus_if.tone_en, bus_if.tone_period, bus_if.tone_duty, bus_if.active_src};
   endfunction

   task automatic test_reset();
      logic [43:0] got;
      rst_n = 1'b0;
      {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = R_NONE;
      repeat (3) @(posedge clk);
      #1;
      got = observed();
      checks++;
      if (got !== 44'd0) begin
         errors++;
         $display("FAIL reset_state: got en=%b per=%h duty=%h src=%0d, want all 0",
                  got[43], got[42:22], got[21:2], got[1:0]);
      end
      rst_n = 1'b1;
      push(50, R_NONE, 1'b0, 2'd0);
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL idle row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
   endtask

   task automatic test_steer_pattern();
      logic [43:0] got;
      push(4, R_S, 1'b1, 2'd1);  push(24, R_S, 1'b0, 2'd1);
      push(4, R_S, 1'b1, 2'd1);  push(24, R_S, 1'b0, 2'd1);
      push(4, R_S, 1'b1, 2'd1);
      push(3, R_NONE, 1'b0, 2'd0);  // drop wins over ON end on the same edge
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL steer row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
   endtask

   task automatic test_ovr_preempt();
      logic [43:0] got;
      push(5, R_B, 1'b1, 2'd2);
      push(8, R_OB, 1'b1, 2'd3);  push(8, R_OB, 1'b0, 2'd3);
      push(2, R_OB, 1'b1, 2'd3);
      push(1, R_B, 1'b0, 2'd0);    // OVR dropped: one silent cycle
      push(12, R_B, 1'b1, 2'd2);  push(20, R_B, 1'b0, 2'd2);
      push(1, R_NONE, 1'b0, 2'd0);
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL ovr_preempt row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
   endtask

   task automatic test_no_lower_preempt();
      logic [43:0] got;
      push(4, R_S, 1'b1, 2'd1);
      push(3, R_S, 1'b0, 2'd1);   push(21, R_BS, 1'b0, 2'd1);
      push(12, R_BS, 1'b1, 2'd2); push(3, R_BS, 1'b0, 2'd2);
      push(1, R_NONE, 1'b0, 2'd0);
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL no_lower_preempt row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
   endtask

   task automatic test_drop_pickup();
      logic [43:0] got;
      push(3, R_BS, 1'b1, 2'd2);   // simultaneous rise: BATT wins
      push(1, R_S, 1'b0, 2'd0);
      push(4, R_S, 1'b1, 2'd1);   push(3, R_S, 1'b0, 2'd1);
      push(3, R_NONE, 1'b0, 2'd0);
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL drop_pickup row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
   endtask

   task automatic test_off_preempt();
      logic [43:0] got;
      push(4, R_S, 1'b1, 2'd1);   push(2, R_S, 1'b0, 2'd1);
      push(8, R_OS, 1'b1, 2'd3);  push(2, R_OS, 1'b0, 2'd3);
      push(6, R_O, 1'b0, 2'd3);    // steer drop ignored while OVR owns the pattern
      push(8, R_O, 1'b1, 2'd3);
      push(1, R_B, 1'b0, 2'd0);
      push(2, R_B, 1'b1, 2'd2);
      push(8, R_O, 1'b1, 2'd3);    // BATT drops as OVR rises: preemption wins
      push(1, R_NONE, 1'b0, 2'd0);
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL off_preempt row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [43:0] got;
      push(3, R_O, 1'b1, 2'd3);
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL async_pre row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
      #1 rst_n = 1'b0;
      #1;
      got = observed();
      checks++;
      if (got !== 44'd0) begin
         errors++;
         $display("FAIL async_reset: got en=%b per=%h duty=%h src=%0d, want all 0",
                  got[43], got[42:22], got[21:2], got[1:0]);
      end
      #1 rst_n = 1'b1;
      push(8, R_O, 1'b1, 2'd3);   push(8, R_O, 1'b0, 2'd3);
      push(1, R_NONE, 1'b0, 2'd0);
      for (int k = 0; sb.size() > 0; k++) begin
         row_t r = sb.pop_front();
         {bus_if.ovr_spd_req, bus_if.batt_low_req, bus_if.en_steer_req} = r.req;
         @(posedge clk); #1;
         got = observed();
         checks++;
         if (got !== r.exp) begin
            errors++;
            $display("FAIL async_post row %0d: got en=%b per=%h duty=%h src=%0d, want en=%b per=%h duty=%h src=%0d",
                     k, got[43], got[42:22], got[21:2], got[1:0], r.exp[43], r.exp[42:22], r.exp[21:2], r.exp[1:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_steer_pattern();
      test_ovr_preempt();
      test_no_lower_preempt();
      test_drop_pickup();
      test_off_preempt();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
